// File: rtl/w4823_fir_ofmt.sv
// FP29-to-FP16 output formatter for the W4823 FIR datapath.
// Two pipeline stages (normalise, then round/classify) feed a small FIFO with a
// valid/ready handshake. Saturation and FIFO-drop events are reported as status.
module w4823_fir_ofmt #(
   parameter int DEPTH      = 4,
   parameter int SAT_TO_INF = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [28:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        ovf,
   output logic [7:0]  sat_cnt,
   input  logic        clr_stat
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Stage-1 leading-one detection and normalisation wires
   logic [4:0]  w_lead;
   logic [4:0]  w_shift;
   logic [21:0] w_normMant;

   // Stage-1 registers
   logic        r_s1Valid;
   logic        r_s1Sign;
   logic [5:0]  r_s1Exp;
   logic [4:0]  r_s1Lead;
   logic [20:0] r_s1Mant;
   logic        r_s1Zero;

   // Stage-2 rounding and classification wires
   logic [9:0]        w_frac;
   logic              w_guard;
   logic              w_sticky;
   logic              w_roundUp;
   logic [10:0]       w_fracSum;
   logic signed [7:0] w_expBiased;
   logic signed [7:0] w_expFinal;
   logic [15:0]       w_result;
   logic              w_sat;

   // Stage-2 registers
   logic        r_s2Valid;
   logic [15:0] r_s2Data;
   logic        r_s2Sat;

   // FIFO storage and control
   logic [15:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wrPtr;
   logic [ADDR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;

   // Status registers
   logic       r_ovf;
   logic [7:0] r_satCnt;

   // Find the highest set mantissa bit and shift it up to bit 21
   always_comb begin
      w_lead = '0;
      for (int i = 0; i < 22; i++) begin
         if (in_data[i]) begin
            w_lead = 5'(i);
         end
      end
      w_shift    = 5'd21 - w_lead;
      w_normMant = in_data[21:0] << w_shift;
   end

   // Stage 1: capture the word with its mantissa already normalised
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_s1Sign  <= 1'b0;
         r_s1Exp   <= '0;
         r_s1Lead  <= '0;
         r_s1Mant  <= '0;
         r_s1Zero  <= 1'b1;
      end else begin
         r_s1Valid <= in_valid;
         r_s1Sign  <= in_data[28];
         r_s1Exp   <= in_data[27:22];
         r_s1Lead  <= w_lead;
         r_s1Mant  <= w_normMant[20:0];
         r_s1Zero  <= ~w_normMant[21];
      end
   end

   // Round to nearest even; a fraction carry-out bumps the exponent
   always_comb begin
      w_frac      = r_s1Mant[20:11];
      w_guard     = r_s1Mant[10];
      w_sticky    = |r_s1Mant[9:0];
      w_roundUp   = w_guard & (w_sticky | w_frac[0]);
      w_fracSum   = {1'b0, w_frac} + {10'b0, w_roundUp};
      w_expBiased = $signed({3'b000, r_s1Lead}) + $signed({2'b00, r_s1Exp}) - 8'sd37;
      w_expFinal  = w_fracSum[10] ? (w_expBiased + 8'sd1) : w_expBiased;
   end

   // Classify the rounded value: zero, flush-to-zero, overflow, or normal
   always_comb begin
      w_result = {r_s1Sign, w_expFinal[4:0], w_fracSum[9:0]};
      w_sat    = 1'b0;
      if (r_s1Zero) begin
         w_result = {r_s1Sign, 15'b0};
      end else if (w_expFinal <= 8'sd0) begin
         w_result = {r_s1Sign, 15'b0};
      end else if (w_expFinal >= 8'sd31) begin
         w_sat = 1'b1;
         if (SAT_TO_INF != 0) begin
            w_result = {r_s1Sign, 5'h1F, 10'h000};
         end else begin
            w_result = {r_s1Sign, 5'h1E, 10'h3FF};
         end
      end
   end

   // Stage 2: hold the formatted FP16 word ready for the FIFO write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s2Valid <= 1'b0;
         r_s2Data  <= '0;
         r_s2Sat   <= 1'b0;
      end else begin
         r_s2Valid <= r_s1Valid;
         r_s2Data  <= w_result;
         r_s2Sat   <= w_sat;
      end
   end

   // A full FIFO still accepts a word when the head leaves on the same edge
   always_comb begin
      w_pop  = out_valid & out_ready;
      w_push = r_s2Valid & ((r_count != FULL_CNT) | w_pop);
      w_drop = r_s2Valid & ~w_push;
   end

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (rst_n && w_push) begin
         r_mem[r_wrPtr] <= r_s2Data;
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + ADDR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky drop flag and saturating overflow counter; a clear wins over a same-edge event
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf    <= 1'b0;
         r_satCnt <= '0;
      end else if (clr_stat) begin
         r_ovf    <= 1'b0;
         r_satCnt <= '0;
      end else begin
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if (r_s2Valid && r_s2Sat && (r_satCnt != 8'hFF)) begin
            r_satCnt <= r_satCnt + 8'd1;
         end
      end
   end

   // The head is shown only while the FIFO holds data, otherwise zero
   always_comb begin
      out_valid = (r_count != '0);
      out_data  = out_valid ? r_mem[r_rdPtr] : 16'h0000;
      ovf       = r_ovf;
      sat_cnt   = r_satCnt;
   end

endmodule
